if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage pipelined LoongArch core that replaces the single-cycle datapath. It owns the PC, computes the next fetch address (sequential or branch redirect from ID), drives the synchronous instruction SRAM, and hands `{inst, pc}` to the decode stage over a valid/allowin handshake. An internal one-entry instruction buffer holds SRAM read data across decode back-pressure.

## Interface
- `RESET_PC`, default 32'h1c000000, address of the first fetched instruction.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `resetn`  in  1  one clock; reset is asynchronous and active-low.
- `ds_allowin`  in  1  ID can accept an instruction this cycle.
- `br_taken`  in  1  ID redirect request, one-cycle pulse, already qualified by ID valid.
- `br_target`  in  32  redirect address, valid when `br_taken`=1.
- `fs_to_ds_valid`  out  1  IF holds a valid instruction for ID.
- `fs_to_ds_bus`  out  64  {fs_inst[63:32], fs_pc[31:0]}.
- `inst_sram_en`  out  1  SRAM read enable.
- `inst_sram_we`  out  1  tied 0.
- `inst_sram_addr`  out  32  fetch address (= nextpc).
- `inst_sram_wdata`  out  32  tied 0.
- `inst_sram_rdata`  in  32  read data, one cycle after an enabled request.

## Operation
- Registers: `started` (reset 0), `fs_valid` (reset 0), `fs_pc` (reset RESET_PC-4), `buf_valid` (reset 0), `inst_buf` (reset 0).
- `started` <= 1 on the first edge after reset deasserts; gates all requests.
- `seq_pc` = fs_pc + 4 (32-bit, wraps modulo 2^32); `nextpc` = br_taken ? br_target : seq_pc.
- `fs_ready_go` = 1; `fs_allowin` = !fs_valid | (fs_ready_go & ds_allowin).
- `inst_sram_en` = started & (fs_allowin | br_taken); `inst_sram_addr` = nextpc.
- On edge with `inst_sram_en`=1: fs_pc <= nextpc, fs_valid <= 1.
- `fs_inst` = buf_valid ? inst_buf : inst_sram_rdata.
- `fs_to_ds_valid` = fs_valid & !br_taken (wrong-path instruction squashed in redirect cycle).
- Buffer: if fs_valid & !ds_allowin & !buf_valid & !br_taken -> capture inst_sram_rdata, buf_valid <= 1. Clear buf_valid when ds_allowin=1 or br_taken=1.
- Redirect: br_taken overrides back-pressure; in that cycle the request to br_target issues regardless of ds_allowin, buffer is flushed, IF instruction discarded.
- Simultaneous br_taken and ds_allowin=0: redirect wins; IF refills with br_target.
- Reset mid-operation: all registers return to reset values asynchronously; outstanding SRAM data is ignored (fs_valid=0).

## Timing
- Reset values: fs_to_ds_valid 0, inst_sram_en 0, inst_sram_addr RESET_PC, fs_to_ds_bus[31:0] RESET_PC-4, bus[63:32] don't-care while invalid.
- After resetn rises: edge 1 sets `started`; cycle 2 issues RESET_PC; cycle 3 fs_to_ds_valid=1 with pc RESET_PC.
- Fetch latency: request cycle N -> instruction valid at IF in cycle N+1.
- Throughput: one instruction per cycle with ds_allowin held 1.
- Branch penalty: one bubble (squashed slot) per redirect; target valid the cycle after br_taken.
- Stall: bus stable (pc and inst unchanged) for every cycle ds_allowin=0; no SRAM request issued.

## Test plan
- Reset release, ds_allowin=1, SRAM returns mem[a]=a^32'hA5A5A5A5 -> pcs 1c000000, 1c000004, 1c000008 on consecutive cycles, first valid 2 cycles after resetn rises, matching inst.
- Hold ds_allowin=0 for 3 cycles at pc 1c000008, SRAM rdata randomised during stall -> bus stays {mem[1c000008], 1c000008}, inst_sram_en=0; release -> 1c00000c next cycle.
- br_taken with br_target=1c000100 while IF holds 1c000010 -> fs_to_ds_valid=0 that cycle, inst_sram_addr=1c000100, next cycle pc 1c000100 valid.
- br_taken during stall (ds_allowin=0, buf_valid=1), target 1c000200 -> buffer cleared, next pc 1c000200 with SRAM data, not old buffered inst.
- fs_pc=FFFFFFFC sequential -> next request address 00000000.
- Assert resetn=0 asynchronously mid-stream -> fs_to_ds_valid and inst_sram_en drop immediately; restart sequence repeats from 1c000000.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the five-stage LoongArch pipeline.
// Owns the PC, picks the next fetch address (sequential or ID redirect),
// drives the synchronous instruction SRAM and presents {inst, pc} to decode
// over a valid/allowin handshake. A one-entry buffer keeps the SRAM read
// data alive while decode applies back-pressure, because the SRAM output
// is only trustworthy in the cycle right after an enabled request.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_en,
    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    logic        started;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        buf_valid;
    logic [31:0] inst_buf;

    logic        fs_ready_go;
    logic        fs_allowin;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic [31:0] fs_inst;

    // Next-PC selection: a redirect from ID always wins over the sequential path
    always_comb begin
        seq_pc = fs_pc + 32'd4;
        nextpc = br_taken ? br_target : seq_pc;
    end

    // Handshake and SRAM request: a redirect issues even while decode is stalled
    always_comb begin
        fs_ready_go     = 1'b1;
        fs_allowin      = !fs_valid || (fs_ready_go && ds_allowin);
        inst_sram_en    = started && (fs_allowin || br_taken);
        inst_sram_we    = 1'b0;
        inst_sram_addr  = nextpc;
        inst_sram_wdata = 32'd0;
    end

    // Output to decode: buffered word takes priority, wrong-path slot squashed on redirect
    always_comb begin
        fs_inst        = buf_valid ? inst_buf : inst_sram_rdata;
        fs_to_ds_valid = fs_valid && !br_taken;
        fs_to_ds_bus   = {fs_inst, fs_pc};
    end

    // Start-up gate: hold off the first request for one cycle after reset release
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    // PC and valid: every accepted request moves IF onto the requested address
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - 32'd4;
        end else if (inst_sram_en) begin
            fs_valid <= 1'b1;
            fs_pc    <= nextpc;
        end
    end

    // Instruction buffer: capture SRAM data on the first stalled cycle, drop on consume or redirect
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
            inst_buf  <= 32'd0;
        end else if (ds_allowin || br_taken) begin
            buf_valid <= 1'b0;
        end else if (fs_valid && !buf_valid) begin
            buf_valid <= 1'b1;
            inst_buf  <= inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed vector table for the documented corner
// cases, an asynchronous reset check, then randomized handshake/redirect
// traffic compared against a behavioural model of the fetch stream.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    int checks = 0;
    int passed = 0;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ds_allowin     (ds_allowin),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hA5A5A5A5;
    endfunction

    // SRAM model: fresh data one cycle after an enabled read, garbage otherwise
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= memWord(inst_sram_addr);
        else              inst_sram_rdata <= $urandom;
    end

    // Reference model of the fetch stream: which pc IF holds and whether it holds one
    logic        m_started;
    logic        m_holding;
    logic [31:0] m_pc;
    logic        m_fetch;
    logic [31:0] m_target;

    always_comb begin
        m_fetch  = m_started && (!m_holding || ds_allowin || br_taken);
        m_target = br_taken ? br_target : m_pc + 32'd4;
    end

    // Model state advance at each edge, cleared by reset
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_started <= 1'b0;
            m_holding <= 1'b0;
            m_pc      <= RESET_PC - 32'd4;
        end else begin
            m_started <= 1'b1;
            if (m_fetch) begin
                m_holding <= 1'b1;
                m_pc      <= m_target;
            end
        end
    end

    typedef struct {
        logic        allow;
        logic        br;
        logic [31:0] tgt;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_en;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[17];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        else
            passed++;
    endtask

    task automatic applyStimulus(input logic allow, input logic br, input logic [31:0] tgt);
        ds_allowin = allow;
        br_taken   = br;
        br_target  = tgt;
    endtask

    task automatic checkVector(input int i);
        checkOutput($sformatf("vec%0d valid", i), 64'(fs_to_ds_valid), 64'(vecs[i].exp_valid));
        checkOutput($sformatf("vec%0d en", i), 64'(inst_sram_en), 64'(vecs[i].exp_en));
        checkOutput($sformatf("vec%0d addr", i), 64'(inst_sram_addr), 64'(vecs[i].exp_addr));
        if (vecs[i].exp_valid)
            checkOutput($sformatf("vec%0d bus", i), fs_to_ds_bus,
                        {memWord(vecs[i].exp_pc), vecs[i].exp_pc});
    endtask

    task automatic checkModel(input int cyc);
        checkOutput($sformatf("rnd%0d valid", cyc), 64'(fs_to_ds_valid),
                    64'(m_holding && !br_taken));
        checkOutput($sformatf("rnd%0d en", cyc), 64'(inst_sram_en), 64'(m_fetch));
        if (m_fetch)
            checkOutput($sformatf("rnd%0d addr", cyc), 64'(inst_sram_addr), 64'(m_target));
        if (m_holding && !br_taken)
            checkOutput($sformatf("rnd%0d bus", cyc), fs_to_ds_bus, {memWord(m_pc), m_pc});
    endtask

    initial begin
        // allow br tgt | valid pc en addr
        vecs[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        1'b0, 32'h1c000000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 32'h1c000000};
        vecs[2]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h1c000000, 1'b1, 32'h1c000004};
        vecs[3]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h1c000004, 1'b1, 32'h1c000008};
        vecs[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h1c000008, 1'b0, 32'h1c00000c};
        vecs[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h1c000008, 1'b0, 32'h1c00000c};
        vecs[6]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h1c000008, 1'b0, 32'h1c00000c};
        vecs[7]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h1c000008, 1'b1, 32'h1c00000c};
        vecs[8]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h1c00000c, 1'b1, 32'h1c000010};
        vecs[9]  = '{1'b1, 1'b1, 32'h1c000100, 1'b0, 32'h0, 1'b1, 32'h1c000100};
        vecs[10] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h1c000100, 1'b1, 32'h1c000104};
        vecs[11] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h1c000104, 1'b0, 32'h1c000108};
        vecs[12] = '{1'b0, 1'b1, 32'h1c000200, 1'b0, 32'h0, 1'b1, 32'h1c000200};
        vecs[13] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h1c000200, 1'b1, 32'h1c000204};
        vecs[14] = '{1'b1, 1'b1, 32'hfffffffc, 1'b0, 32'h0, 1'b1, 32'hfffffffc};
        vecs[15] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'hfffffffc, 1'b1, 32'h00000000};
        vecs[16] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h00000000, 1'b1, 32'h00000004};

        resetn = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset valid", 64'(fs_to_ds_valid), 64'd0);
        checkOutput("reset en", 64'(inst_sram_en), 64'd0);
        checkOutput("reset addr", 64'(inst_sram_addr), 64'(RESET_PC));
        checkOutput("reset pc", 64'(fs_to_ds_bus[31:0]), 64'(RESET_PC - 32'd4));
        checkOutput("sram we", 64'(inst_sram_we), 64'd0);
        checkOutput("sram wdata", 64'(inst_sram_wdata), 64'd0);

        @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].allow, vecs[i].br, vecs[i].tgt);
            @(negedge clk);
            checkVector(i);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset between edges while fetching
        applyStimulus(1'b1, 1'b0, 32'h0);
        #2 resetn = 1'b0;
        #1;
        checkOutput("async valid", 64'(fs_to_ds_valid), 64'd0);
        checkOutput("async en", 64'(inst_sram_en), 64'd0);
        checkOutput("async addr", 64'(inst_sram_addr), 64'(RESET_PC));
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].allow, vecs[i].br, vecs[i].tgt);
            @(negedge clk);
            checkVector(i);
            @(posedge clk);
            #1;
        end

        // Randomized back-pressure and redirects against the model
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                          $urandom & 32'hfffffffc);
            @(negedge clk);
            checkModel(c);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
